// File: rtl/tri_arb_pkg.sv
// tri_arb_pkg: shared FSM encodings and widths for tri_assign_arbiter.
package tri_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;
    localparam int HOLD_W = 4;
    localparam int CNT_W = 16;
endpackage

// File: rtl/tri_assign_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting one past the last winner.
module rr_pick #(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] w
);
    logic [IW-1:0] idx;
    assign any = |req;
    // Walk from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        w = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % N);
            if (req[idx]) w = idx;
        end
    end
endmodule

// File: rtl/tri_assign_arbiter.sv
// tri_assign_arbiter: round-robin sharing of one tri_assignment unit.
// Define TRI_ARB_STATS_EN to add the saturating op_count port.
module tri_assign_arbiter
    import tri_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int HOLD_CYCLES = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0] gnt,
    output logic               op_a,
    output logic               op_b,
    input  logic [2:0]         unit_c,
    output logic               res_valid,
    output logic [IW-1:0]      res_id,
    output logic [2:0]         res_c
`ifdef TRI_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   op_count
`endif
);
    state_t state, nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IW-1:0] last, w;
    logic any, grab, cap;

    rr_pick #(.N(NUM_REQ)) u_pick (.req(req), .last(last), .any(any), .w(w));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (any ? GRANT : IDLE) :
              (state == GRANT) ? (cap ? DONE : GRANT) : IDLE;
    end

    always_comb begin
        grab = (state == IDLE) && any;
        cap = (state == GRANT) && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    end

    // last doubles as the owner of the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            last <= IW'(NUM_REQ - 1);
            gnt <= '0;
            op_a <= 1'b0;
            op_b <= 1'b0;
            res_valid <= 1'b0;
            res_id <= '0;
            res_c <= '0;
        end else begin
            res_valid <= cap;
            hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
            if (grab) begin
                gnt <= NUM_REQ'(1) << w;
                last <= w;
                op_a <= req_a[w];
                op_b <= req_b[w];
            end
            if (cap) begin
                gnt <= '0;
                res_c <= unit_c;
                res_id <= last;
            end
        end
    end

`ifdef TRI_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_count <= '0;
        else if (res_valid && op_count != '1) op_count <= op_count + 1'b1;
    end
`endif
endmodule
